// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code stream to ASCII characters.
// Tracks make/break/extended prefixes and shift/caps-lock state, and buffers output in a ready/valid FIFO.
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [7:0]  UNKNOWN_CHAR = 8'h2E,
  parameter bit          DROP_UNKNOWN = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    scan_code,
  input  logic                          scan_valid,
  output logic [7:0]                    ascii,
  output logic                          ascii_valid,
  input  logic                          ascii_ready,
  output logic                          shift_active,
  output logic                          caps_lock,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t          state, state_nxt;
  logic            lshift, rshift, caps_held;
  logic            lshift_nxt, rshift_nxt, caps_held_nxt, caps_lock_nxt;
  logic            push_c;
  logic [7:0]      push_char_c;

  logic [7:0]      letter_c, digit_c, sym_c, other_c;
  logic            upper_c, map_hit_c;
  logic [7:0]      map_char_c;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [CW-1:0]   count_nxt;
  logic            full_c, pop_c, push_ok_c, drop_c;
  logic [7:0]      head_nxt_c;

  // Character lookup for a non-extended make code; zero means "not in this class".
  always_comb begin
    letter_c = 8'h00;
    digit_c  = 8'h00;
    sym_c    = 8'h00;
    other_c  = 8'h00;
    case (scan_code)
      8'h1C: letter_c = "A";  8'h32: letter_c = "B";  8'h21: letter_c = "C";
      8'h23: letter_c = "D";  8'h24: letter_c = "E";  8'h2B: letter_c = "F";
      8'h34: letter_c = "G";  8'h33: letter_c = "H";  8'h43: letter_c = "I";
      8'h3B: letter_c = "J";  8'h42: letter_c = "K";  8'h4B: letter_c = "L";
      8'h3A: letter_c = "M";  8'h31: letter_c = "N";  8'h44: letter_c = "O";
      8'h4D: letter_c = "P";  8'h15: letter_c = "Q";  8'h2D: letter_c = "R";
      8'h1B: letter_c = "S";  8'h2C: letter_c = "T";  8'h3C: letter_c = "U";
      8'h2A: letter_c = "V";  8'h1D: letter_c = "W";  8'h22: letter_c = "X";
      8'h35: letter_c = "Y";  8'h1A: letter_c = "Z";
      8'h45: {digit_c, sym_c} = {"0", ")"};
      8'h16: {digit_c, sym_c} = {"1", "!"};
      8'h1E: {digit_c, sym_c} = {"2", "@"};
      8'h26: {digit_c, sym_c} = {"3", "#"};
      8'h25: {digit_c, sym_c} = {"4", "$"};
      8'h2E: {digit_c, sym_c} = {"5", "%"};
      8'h36: {digit_c, sym_c} = {"6", "^"};
      8'h3D: {digit_c, sym_c} = {"7", "&"};
      8'h3E: {digit_c, sym_c} = {"8", "*"};
      8'h46: {digit_c, sym_c} = {"9", "("};
      8'h29: other_c = 8'h20;
      8'h5A: other_c = 8'h0D;
      8'h66: other_c = 8'h08;
      8'h0D: other_c = 8'h09;
      default: ;
    endcase
    upper_c   = shift_active ^ caps_lock;
    map_hit_c = (letter_c != 8'h00) || (digit_c != 8'h00) || (other_c != 8'h00);
    if (letter_c != 8'h00)
      map_char_c = upper_c ? letter_c : letter_c + 8'h20;
    else if (digit_c != 8'h00)
      map_char_c = shift_active ? sym_c : digit_c;
    else
      map_char_c = other_c;
  end

  // Prefix FSM: next state, modifier updates and character push request.
  always_comb begin
    state_nxt     = state;
    lshift_nxt    = lshift;
    rshift_nxt    = rshift;
    caps_held_nxt = caps_held;
    caps_lock_nxt = caps_lock;
    push_c        = 1'b0;
    push_char_c   = map_char_c;
    if (scan_valid) begin
      case (state)
        IDLE: begin
          case (scan_code)
            8'hF0: state_nxt = BRK;
            8'hE0: state_nxt = EXT;
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
            8'h12: lshift_nxt = 1'b1;
            8'h59: rshift_nxt = 1'b1;
            8'h58: begin
              // Typematic repeats of caps-lock must not re-toggle.
              if (!caps_held) caps_lock_nxt = ~caps_lock;
              caps_held_nxt = 1'b1;
            end
            default: begin
              if (map_hit_c) begin
                push_c = 1'b1;
              end else if (!DROP_UNKNOWN) begin
                push_c      = 1'b1;
                push_char_c = UNKNOWN_CHAR;
              end
            end
          endcase
        end
        BRK: begin
          state_nxt = IDLE;
          case (scan_code)
            8'h12:   lshift_nxt    = 1'b0;
            8'h59:   rshift_nxt    = 1'b0;
            8'h58:   caps_held_nxt = 1'b0;
            default: ;
          endcase
        end
        EXT: begin
          if (scan_code == 8'hF0) begin
            state_nxt = EXT_BRK;
          end else begin
            state_nxt = IDLE;
            if (scan_code == 8'h5A) begin
              push_c      = 1'b1;
              push_char_c = 8'h0D;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lshift       <= 1'b0;
      rshift       <= 1'b0;
      caps_held    <= 1'b0;
      caps_lock    <= 1'b0;
      shift_active <= 1'b0;
    end else begin
      state        <= state_nxt;
      lshift       <= lshift_nxt;
      rshift       <= rshift_nxt;
      caps_held    <= caps_held_nxt;
      caps_lock    <= caps_lock_nxt;
      shift_active <= lshift_nxt | rshift_nxt;
    end
  end

  // FIFO control; ascii is a registered copy of the head entry.
  always_comb begin
    full_c     = (fifo_count == CW'(FIFO_DEPTH));
    pop_c      = ascii_valid & ascii_ready;
    push_ok_c  = push_c & (~full_c | pop_c);
    drop_c     = push_c & full_c & ~pop_c;
    rd_ptr_nxt = pop_c ? rd_ptr + AW'(1) : rd_ptr;
    count_nxt  = fifo_count;
    case ({push_ok_c, pop_c})
      2'b10:   count_nxt = fifo_count + CW'(1);
      2'b01:   count_nxt = fifo_count - CW'(1);
      default: ;
    endcase
    head_nxt_c = (push_ok_c && (wr_ptr == rd_ptr_nxt)) ? push_char_c : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_char_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      ascii       <= 8'h00;
      ascii_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      rd_ptr      <= rd_ptr_nxt;
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      fifo_count  <= count_nxt;
      ascii_valid <= (count_nxt != '0);
      if ((push_ok_c || pop_c) && (count_nxt != '0)) ascii <= head_nxt_c;
      if (drop_c) overflow <= 1'b1;
    end
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Converts the PS/2 Set-2 scan-code byte stream into buffered ASCII characters.
- Tracks make/break and extended prefixes, plus shift and caps-lock state.
- Outputs printable characters in the correct case through a ready/valid FIFO.
- Sits between the PS/2 byte receiver and the LCD/character consumer; supersedes the purely combinational keycode lookup.

Parameters:
- FIFO_DEPTH, 8, output FIFO entries; power of 2, at least 2.
- UNKNOWN_CHAR, 8'h2E, character emitted for an unmapped non-extended make code.
- DROP_UNKNOWN, 0, when 1 unmapped make codes emit nothing.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- scan_code  input  8  received PS/2 byte.
- scan_valid  input  1  one-cycle strobe, scan_code valid.
- ascii  output  8  FIFO head character.
- ascii_valid  output  1  FIFO non-empty.
- ascii_ready  input  1  consumer accepts head when ascii_valid is high.
- shift_active  output  1  left or right shift currently held.
- caps_lock  output  1  caps-lock toggle state.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held.
- overflow  output  1  sticky, a character was dropped because the FIFO was full.

Behaviour:
- Reset (async, active-high) forces the following; a reset mid-sequence discards any pending prefix:
  - FSM to IDLE, FIFO empty, ascii=8'h00.
  - ascii_valid=0, shift_active=0, caps_lock=0, fifo_count=0, overflow=0.
  - Internal lshift, rshift and caps_held cleared.
- FSM advances only on scan_valid; scan_code is ignored when scan_valid=0. States:
  - IDLE:
    - 8'hF0 -> BRK.
    - 8'hE0 -> EXT.
    - 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF are ignored and stay in IDLE.
    - Any other byte is a make code: process it, stay in IDLE.
  - BRK: the next byte is a break code; process the release and return to IDLE.
  - EXT: 8'hF0 -> EXT_BRK; any other byte is an extended make and returns to IDLE.
  - EXT_BRK: the next byte is an extended break; no action, return to IDLE.
- Make processing:
  - 8'h12 sets lshift; 8'h59 sets rshift.
  - 8'h58 toggles caps_lock only if caps_held=0, then sets caps_held, so typematic repeats do not re-toggle.
  - Letters (1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z):
    - uppercase when shift_active XOR caps_lock;
    - otherwise lowercase (upper + 8'h20).
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 map to "0".."9" when unshifted. With shift they map to ")!@#$%^&*(" respectively; caps_lock does not affect digits.
  - 29 -> 8'h20 (space), 5A -> 8'h0D, 66 -> 8'h08, 0D -> 8'h09.
  - Any other make pushes UNKNOWN_CHAR, or nothing if DROP_UNKNOWN=1.
- Extended make: E0 5A pushes 8'h0D; all other extended makes push nothing.
- Break processing: 12 clears lshift, 59 clears rshift, 58 clears caps_held; other breaks have no effect.
- shift_active = lshift | rshift, registered; it updates the cycle after the scan byte.
- FIFO:
  - push in cycle N of scan_valid; character visible on ascii with ascii_valid=1 at cycle N+1 if the FIFO was empty.
  - Pop when ascii_valid & ascii_ready.
  - Push while full with no pop: character dropped, overflow=1 until reset, count unchanged.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push and pop in the same cycle when empty: push only, since ascii_valid was 0.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - ascii holds the head value while ascii_valid=0 is don't-care but stable.

Test Plan:
- Post-reset, send 1C with ascii_ready=1 -> ascii=8'h61 'a' with ascii_valid high for 1 cycle at N+1; fifo_count returns to 0.
- Send 12,1C,F0,12,1C -> "A" then "a"; shift_active high between 12 and the F0 12 break.
- Send 58,58,58,F0,58 then 1C, 16 -> caps_lock=1 (single toggle), then "A" and "1"; add 59 held then 1C -> "a", 16 -> "!".
- Send E0,F0,1C then E0,5A then E0,75 -> only 8'h0D is pushed; the FSM returns to IDLE each time and no spurious "a" is emitted.
- FIFO_DEPTH=8, ascii_ready=0, send 10 codes of 16 -> fifo_count=8, overflow=1; then drain to get eight 8'h31 characters in order.
- Assert reset mid-sequence after F0 with 3 characters queued -> all outputs zero immediately; the next byte 1C is treated as a make -> "a".
